// File: rtl/pipeline_flow_control.sv
// pipeline_flow_control: per-stage valid tracking, hold/advance with bubble squashing, control-flow stall or flush, perf counters
// Ports: clock/reset (async active-low); fetch_valid, fetch_is_control, stall_req[STAGES],
// resolve_valid, resolve_redirect in; pc_write_enable, fetch_accept, stage_advance, flush (combinational),
// stage_valid, branch_pending, stall_count, flush_count (registered) out.
module pipeline_flow_control #(
  parameter int STAGES = 4,
  parameter int RESOLVE_STAGE = 1,
  parameter int PREDICT = 0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 fetch_valid,
  input  logic                 fetch_is_control,
  input  logic [STAGES-1:0]    stall_req,
  input  logic                 resolve_valid,
  input  logic                 resolve_redirect,
  output logic                 pc_write_enable,
  output logic                 fetch_accept,
  output logic [STAGES-1:0]    stage_advance,
  output logic [STAGES-1:0]    stage_valid,
  output logic [STAGES-1:0]    flush,
  output logic                 branch_pending,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_nx;
  logic [STAGES-1:0] hold, valid_nx;
  logic redirect;
  assign redirect = resolve_valid & resolve_redirect;
  // hold propagates from the oldest stage backwards; invalid stages break the chain so bubbles get squashed
  always_comb begin
    hold = '0;
    hold[STAGES-1] = stage_valid[STAGES-1] & stall_req[STAGES-1];
    for (int i = STAGES-2; i >= 0; i--) hold[i] = stage_valid[i] & (stall_req[i] | hold[i+1]);
  end
  always_comb begin
    flush = '0;
    for (int i = 0; i < STAGES; i++) flush[i] = redirect & (i < RESOLVE_STAGE);
  end
  assign stage_advance = ~hold;
  assign fetch_accept = (state == IDLE) & fetch_valid & ~hold[0] & ~redirect;
  assign pc_write_enable = (state == WAIT) ? resolve_valid : (fetch_accept | redirect);
  assign branch_pending = (state == WAIT);
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = (PREDICT == 0 && fetch_accept && fetch_is_control) ? WAIT : IDLE;
    else state_nx = resolve_valid ? IDLE : WAIT;
  end
  // flush beats hold, hold keeps the bit, otherwise the stage takes what the previous stage releases
  always_comb begin
    valid_nx = '0;
    valid_nx[0] = flush[0] ? 1'b0 : hold[0] ? stage_valid[0] : fetch_accept;
    for (int i = 1; i < STAGES; i++)
      valid_nx[i] = flush[i] ? 1'b0 : hold[i] ? stage_valid[i] : (stage_valid[i-1] & ~hold[i-1]);
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      stage_valid <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state <= state_nx;
      stage_valid <= valid_nx;
      stall_count <= stall_count + {{(CNT_WIDTH-1){1'b0}}, fetch_valid & ~fetch_accept & ~&stall_count};
      flush_count <= flush_count + {{(CNT_WIDTH-1){1'b0}}, redirect & ~&flush_count};
    end
  end
endmodule

// File: tb/tb_pipeline_flow_control.sv
// tb_pipeline_flow_control: scoreboard bench for a stall-mode and a predict-mode instance
module tb_pipeline_flow_control;
  localparam int PWE = 0, FA = 1, ADV = 2, SV = 3, FL = 4, BP = 5, SC = 6, FC = 7;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n [2];
  logic fv [2], fc [2], rv [2], rr [2];
  logic [3:0] sr [2];
  logic pwe [2], fa [2], bp [2];
  logic [3:0] adv [2], sv [2], fl [2];
  logic [15:0] sc0, fcn0;
  logic [3:0] sc1, fcn1;
  int checks = 0, failures = 0;

  pipeline_flow_control #(.STAGES(4), .RESOLVE_STAGE(1), .PREDICT(0), .CNT_WIDTH(16)) dut0 (
    .clock(clk), .reset(rst_n[0]), .fetch_valid(fv[0]), .fetch_is_control(fc[0]), .stall_req(sr[0]),
    .resolve_valid(rv[0]), .resolve_redirect(rr[0]), .pc_write_enable(pwe[0]), .fetch_accept(fa[0]),
    .stage_advance(adv[0]), .stage_valid(sv[0]), .flush(fl[0]), .branch_pending(bp[0]),
    .stall_count(sc0), .flush_count(fcn0));

  pipeline_flow_control #(.STAGES(4), .RESOLVE_STAGE(2), .PREDICT(1), .CNT_WIDTH(4)) dut1 (
    .clock(clk), .reset(rst_n[1]), .fetch_valid(fv[1]), .fetch_is_control(fc[1]), .stall_req(sr[1]),
    .resolve_valid(rv[1]), .resolve_redirect(rr[1]), .pc_write_enable(pwe[1]), .fetch_accept(fa[1]),
    .stage_advance(adv[1]), .stage_valid(sv[1]), .flush(fl[1]), .branch_pending(bp[1]),
    .stall_count(sc1), .flush_count(fcn1));

  typedef struct {int d; int id; logic [15:0] v; string tag;} exp_t;
  exp_t sb[$];

  function automatic logic [15:0] get(int d, int id);
    case (id)
      PWE: return {15'b0, pwe[d]};
      FA:  return {15'b0, fa[d]};
      ADV: return {12'b0, adv[d]};
      SV:  return {12'b0, sv[d]};
      FL:  return {12'b0, fl[d]};
      BP:  return {15'b0, bp[d]};
      SC:  return (d == 0) ? sc0 : {12'b0, sc1};
      default: return (d == 0) ? fcn0 : {12'b0, fcn1};
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic push(input int d, input int id, input logic [15:0] v, input string tag);
    exp_t e;
    e.d = d; e.id = id; e.v = v; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic drain();
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.tag, get(e.d, e.id), e.v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic settle();
    #1;
    drain();
  endtask

  task automatic drv(input int d, input logic v, input logic c, input logic [3:0] s, input logic r, input logic rd);
    fv[d] = v; fc[d] = c; sr[d] = s; rv[d] = r; rr[d] = rd;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0;
      drv(d, 0, 0, 4'b0, 0, 0);
    end
    #2;
    for (int d = 0; d < 2; d++) begin
      push(d, SV, 0, "rst_sv"); push(d, BP, 0, "rst_bp"); push(d, SC, 0, "rst_sc");
      push(d, FC, 0, "rst_fc"); push(d, FA, 0, "rst_fa"); push(d, ADV, 4'hf, "rst_adv");
    end
    drain();
    @(posedge clk); #1;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    // stall-mode instance: fill, bubble squash
    drv(0, 1, 0, 4'b0, 0, 0);
    push(0, FA, 1, "fill_fa"); push(0, PWE, 1, "fill_pwe"); settle();
    repeat (3) tick();
    push(0, SV, 4'hf, "fill_sv"); tick();
    drv(0, 1, 0, 4'b0100, 0, 0);
    push(0, ADV, 4'b1000, "bub_adv"); push(0, FA, 0, "bub_fa"); push(0, PWE, 0, "bub_pwe"); settle();
    push(0, SV, 4'b0111, "bub_sv1"); push(0, SC, 1, "bub_sc1"); tick();
    push(0, ADV, 4'b1000, "bub_adv2"); settle();
    push(0, SV, 4'b0111, "bub_sv2"); push(0, SC, 2, "bub_sc2"); tick();
    drv(0, 1, 0, 4'b0, 0, 0);
    push(0, ADV, 4'hf, "rel_adv"); push(0, FA, 1, "rel_fa"); settle();
    push(0, SV, 4'hf, "rel_sv"); push(0, SC, 2, "rel_sc"); tick();
    // build valid=1010 then squash around a held oldest stage
    drv(0, 0, 0, 4'b0, 0, 0); push(0, SV, 4'b1110, "sq_sv1"); tick();
    drv(0, 1, 0, 4'b0, 0, 0); push(0, SV, 4'b1101, "sq_sv2"); tick();
    drv(0, 0, 0, 4'b0, 0, 0); push(0, SV, 4'b1010, "sq_sv3"); tick();
    drv(0, 1, 0, 4'b1000, 0, 0);
    push(0, ADV, 4'b0111, "sq_adv"); push(0, FA, 1, "sq_fa"); settle();
    push(0, SV, 4'b1101, "sq_sv4"); tick();
    // branch fetched, wait two cycles, resolve not-taken
    drv(0, 1, 1, 4'b0, 0, 0);
    push(0, FA, 1, "br_fa"); push(0, PWE, 1, "br_pwe"); settle();
    push(0, BP, 1, "br_bp"); push(0, SV, 4'b1011, "br_sv"); tick();
    drv(0, 1, 0, 4'b0, 0, 0);
    push(0, FA, 0, "w1_fa"); push(0, PWE, 0, "w1_pwe"); settle();
    push(0, BP, 1, "w1_bp"); push(0, SV, 4'b0110, "w1_sv"); push(0, SC, 3, "w1_sc"); tick();
    drv(0, 1, 0, 4'b0, 1, 0);
    push(0, FA, 0, "w2_fa"); push(0, PWE, 1, "w2_pwe"); push(0, FL, 0, "w2_fl"); settle();
    push(0, BP, 0, "w2_bp"); push(0, SC, 4, "w2_sc"); push(0, SV, 4'b1100, "w2_sv"); push(0, FC, 0, "w2_fc"); tick();
    drv(0, 1, 0, 4'b0, 0, 0);
    push(0, FA, 1, "idle_fa"); settle();
    push(0, SV, 4'b1001, "idle_sv"); tick();
    // taken branch resolved in WAIT
    drv(0, 1, 1, 4'b0, 0, 0); push(0, SV, 4'b0011, "tk_sv1"); push(0, BP, 1, "tk_bp"); tick();
    drv(0, 1, 0, 4'b0, 0, 0); push(0, SV, 4'b0110, "tk_sv2"); push(0, SC, 5, "tk_sc"); tick();
    drv(0, 1, 0, 4'b0, 1, 1);
    push(0, FL, 4'b0001, "tk_fl"); push(0, PWE, 1, "tk_pwe"); push(0, FA, 0, "tk_fa"); settle();
    push(0, SV, 4'b1100, "tk_sv3"); push(0, FC, 1, "tk_fc"); push(0, BP, 0, "tk_bp2"); push(0, SC, 6, "tk_sc2"); tick();
    // reset asserted mid-WAIT
    drv(0, 1, 0, 4'b0, 0, 0);
    repeat (3) tick();
    push(0, SV, 4'hf, "rw_fill"); tick();
    drv(0, 1, 1, 4'b0, 0, 0); push(0, BP, 1, "rw_bp"); push(0, SV, 4'hf, "rw_sv"); tick();
    drv(0, 1, 0, 4'b0, 0, 0);
    #2;
    rst_n[0] = 1'b0;
    push(0, SV, 0, "rw_sv0"); push(0, BP, 0, "rw_bp0"); push(0, SC, 0, "rw_sc0");
    push(0, FC, 0, "rw_fc0"); push(0, FL, 0, "rw_fl0"); settle();
    @(posedge clk); #1;
    rst_n[0] = 1'b1;
    push(0, FA, 1, "rw_fa"); settle();
    push(0, SV, 4'b0001, "rw_sv1"); tick();
    drv(0, 0, 0, 4'b0, 0, 0);
    // predict-mode instance: not-taken branches cost nothing
    drv(1, 1, 1, 4'b0, 0, 0);
    push(1, FA, 1, "p_fa"); settle();
    repeat (3) tick();
    push(1, SV, 4'hf, "p_sv"); push(1, BP, 0, "p_bp"); tick();
    drv(1, 1, 0, 4'b0, 1, 1);
    push(1, FL, 4'b0011, "p_fl"); push(1, FA, 0, "p_fa0"); push(1, PWE, 1, "p_pwe"); push(1, ADV, 4'hf, "p_adv"); settle();
    push(1, FC, 1, "p_fc1"); push(1, SV, 4'b1100, "p_sv2"); push(1, SC, 1, "p_sc1"); tick();
    drv(1, 1, 0, 4'b0, 0, 0);
    tick();
    tick();
    push(1, SV, 4'b0111, "p_sv3"); tick();
    // flush wins over stall on the same stage
    drv(1, 1, 0, 4'b0011, 1, 1);
    push(1, FL, 4'b0011, "fw_fl"); push(1, ADV, 4'b1100, "fw_adv"); push(1, FA, 0, "fw_fa"); settle();
    push(1, SV, 4'b1000, "fw_sv"); push(1, FC, 2, "fw_fc"); push(1, SC, 2, "fw_sc"); tick();
    // counter saturation at 4 bits
    drv(1, 1, 0, 4'b0, 0, 0); push(1, SV, 4'b0001, "sat_sv0"); tick();
    drv(1, 1, 0, 4'b0001, 0, 0);
    push(1, FA, 0, "sat_fa"); settle();
    repeat (12) tick();
    push(1, SC, 14, "sat_sc14"); settle();
    push(1, SC, 15, "sat_sc15"); tick();
    repeat (6) tick();
    push(1, SC, 15, "sat_hold"); push(1, SV, 4'b0001, "sat_sv"); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
